// File: rtl/screen_scan_seq.sv
// rtl/screen_scan_seq.sv - pixel-address sequencer walking a cols x rows frame with line stride
// Optional continuous-frame mode: define SCAN_FRAME_LOOP_EN.
module screen_scan_seq #(
    parameter int ADDR_W = 13,
    parameter int COL_W  = 8,
    parameter int ROW_W  = 8
) (
    input  logic              sck,
    input  logic              rst,
    input  logic              start,
    input  logic              stop,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W-1:0] stride,
    input  logic [COL_W-1:0]  cols,
    input  logic [ROW_W-1:0]  rows,
    output logic [ADDR_W-1:0] addr,
    output logic              addr_valid,
    input  logic              addr_ready,
    output logic              line_start,
    output logic              busy,
    output logic              done
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);
    localparam logic [COL_W-1:0]  COL_ONE  = COL_W'(1);
    localparam logic [ROW_W-1:0]  ROW_ONE  = ROW_W'(1);

    logic [1:0]        state;
    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W-1:0] line_base;
    logic [ADDR_W-1:0] stride_q;
    logic [COL_W-1:0]  col;
    logic [COL_W-1:0]  cols_q;
    logic [ROW_W-1:0]  row;
    logic [ROW_W-1:0]  rows_q;
    logic              done_q;

    logic              geom_ok;
    logic              xfer;
    logic              last_col;
    logic              last_row;
    logic [ADDR_W-1:0] next_line_base;

    assign geom_ok        = (cols != '0) && (rows != '0);
    assign xfer           = (state == ST_RUN) && addr_ready;
    assign last_col       = (col == (cols_q - COL_ONE));
    assign last_row       = (row == (rows_q - ROW_ONE));
    assign next_line_base = line_base + stride_q;

    assign addr       = addr_q;
    assign addr_valid = (state == ST_RUN);
    assign busy       = (state == ST_RUN);
    assign line_start = (state == ST_RUN) && (col == '0);
    assign done       = done_q;

    always_ff @(posedge sck or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            addr_q    <= '0;
            line_base <= '0;
            stride_q  <= '0;
            col       <= '0;
            cols_q    <= '0;
            row       <= '0;
            rows_q    <= '0;
            done_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                ST_IDLE: begin
                    // stop has priority over start so a racing abort never launches a frame
                    if (start && !stop) begin
                        if (geom_ok) begin
                            stride_q  <= stride;
                            cols_q    <= cols;
                            rows_q    <= rows;
                            addr_q    <= base_addr;
                            line_base <= base_addr;
                            col       <= '0;
                            row       <= '0;
                            state     <= ST_RUN;
                        end else begin
                            state  <= ST_DONE;
                            done_q <= 1'b1;
                        end
                    end
                end
                ST_RUN: begin
                    if (stop) begin
                        state <= ST_IDLE;
                    end else if (xfer) begin
                        if (!last_col) begin
                            col    <= col + COL_ONE;
                            addr_q <= addr_q + ADDR_ONE;
                        end else if (!last_row) begin
                            // jump straight to the next line start, no idle cycle
                            col       <= '0;
                            row       <= row + ROW_ONE;
                            line_base <= next_line_base;
                            addr_q    <= next_line_base;
                        end else begin
                            done_q <= 1'b1;
`ifdef SCAN_FRAME_LOOP_EN
                            if (geom_ok) begin
                                stride_q  <= stride;
                                cols_q    <= cols;
                                rows_q    <= rows;
                                addr_q    <= base_addr;
                                line_base <= base_addr;
                                col       <= '0;
                                row       <= '0;
                            end else begin
                                state <= ST_DONE;
                            end
`else
                            state <= ST_DONE;
`endif
                        end
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_screen_scan_seq.sv
// tb/tb_screen_scan_seq.sv - directed self-checking bench for screen_scan_seq
module tb_screen_scan_seq;

    logic        sck = 1'b0;
    logic        rst;
    logic        start;
    logic        stop;
    logic [12:0] base_addr;
    logic [12:0] stride;
    logic [7:0]  cols;
    logic [7:0]  rows;
    logic [12:0] addr;
    logic        addr_valid;
    logic        addr_ready;
    logic        line_start;
    logic        busy;
    logic        done;

    int n_cmp = 0;
    int n_bad = 0;
    logic [12:0] exp_a [0:5];

    screen_scan_seq dut (
        .sck        (sck),
        .rst        (rst),
        .start      (start),
        .stop       (stop),
        .base_addr  (base_addr),
        .stride     (stride),
        .cols       (cols),
        .rows       (rows),
        .addr       (addr),
        .addr_valid (addr_valid),
        .addr_ready (addr_ready),
        .line_start (line_start),
        .busy       (busy),
        .done       (done)
    );

    always #5 sck = ~sck;

    task automatic tick;
        @(posedge sck);
        #1;
    endtask

    task automatic load_basic;
        base_addr = 13'h100; stride = 13'h040; cols = 8'd3; rows = 8'd2;
        exp_a[0] = 13'h100; exp_a[1] = 13'h101; exp_a[2] = 13'h102;
        exp_a[3] = 13'h140; exp_a[4] = 13'h141; exp_a[5] = 13'h142;
    endtask

    task automatic test_reset;
        rst = 1'b1; start = 1'b0; stop = 1'b0; addr_ready = 1'b1;
        base_addr = '0; stride = '0; cols = '0; rows = '0;
        tick; tick;
        n_cmp++; if ({addr, addr_valid, line_start, busy, done} !== 17'h0) begin
            n_bad++; $display("FAIL reset_outputs: got %h want 0", {addr, addr_valid, line_start, busy, done});
        end
        rst = 1'b0;
        tick;
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_idle_busy: got %b want 0", busy); end
    endtask

    task automatic test_basic_frame;
        load_basic; addr_ready = 1'b1; start = 1'b1;
        tick; start = 1'b0;
        for (int i = 0; i < 6; i++) begin
            n_cmp++; if (addr_valid !== 1'b1 || addr !== exp_a[i]) begin
                n_bad++; $display("FAIL basic_addr[%0d]: got v=%b a=%h want v=1 a=%h", i, addr_valid, addr, exp_a[i]);
            end
            n_cmp++; if (line_start !== (i == 0 || i == 3)) begin
                n_bad++; $display("FAIL basic_line_start[%0d]: got %b want %b", i, line_start, (i == 0 || i == 3));
            end
            n_cmp++; if (done !== 1'b0 || busy !== 1'b1) begin
                n_bad++; $display("FAIL basic_busy[%0d]: got done=%b busy=%b want 0/1", i, done, busy);
            end
            tick;
        end
        n_cmp++; if (done !== 1'b1 || busy !== 1'b0 || addr_valid !== 1'b0) begin
            n_bad++; $display("FAIL basic_done: got done=%b busy=%b v=%b want 1/0/0", done, busy, addr_valid);
        end
        tick;
        n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL basic_done_width: got %b want 0", done); end
    endtask

    task automatic test_backpressure;
        int n;
        int cyc;
        logic held;
        logic [12:0] prev;
        load_basic; addr_ready = 1'b1; start = 1'b1;
        tick; start = 1'b0;
        n = 0; cyc = 0; held = 1'b0; prev = '0;
        while (n < 6 && cyc < 40) begin
            addr_ready = (cyc % 2 == 0);
            if (held) begin
                n_cmp++; if (addr !== prev || addr_valid !== 1'b1) begin
                    n_bad++; $display("FAIL bp_hold[%0d]: got v=%b a=%h want v=1 a=%h", cyc, addr_valid, addr, prev);
                end
            end
            if (addr_valid && addr_ready) begin
                n_cmp++; if (addr !== exp_a[n]) begin
                    n_bad++; $display("FAIL bp_addr[%0d]: got %h want %h", n, addr, exp_a[n]);
                end
                n++;
            end
            held = addr_valid && !addr_ready;
            prev = addr;
            tick;
            cyc++;
        end
        n_cmp++; if (n !== 6) begin n_bad++; $display("FAIL bp_count: got %0d want 6", n); end
        n_cmp++; if (done !== 1'b1 || addr_valid !== 1'b0) begin
            n_bad++; $display("FAIL bp_done: got done=%b v=%b want 1/0", done, addr_valid);
        end
        addr_ready = 1'b1;
        tick;
    endtask

    task automatic test_wrap;
        logic [12:0] w [0:3];
        w[0] = 13'h1FFE; w[1] = 13'h1FFF; w[2] = 13'h0000; w[3] = 13'h0001;
        base_addr = 13'h1FFE; stride = 13'h0; cols = 8'd4; rows = 8'd1;
        addr_ready = 1'b1; start = 1'b1;
        tick; start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            n_cmp++; if (addr_valid !== 1'b1 || addr !== w[i]) begin
                n_bad++; $display("FAIL wrap_addr[%0d]: got v=%b a=%h want v=1 a=%h", i, addr_valid, addr, w[i]);
            end
            tick;
        end
        n_cmp++; if (done !== 1'b1) begin n_bad++; $display("FAIL wrap_done: got %b want 1", done); end
        tick;
    endtask

    task automatic test_zero_size;
        base_addr = 13'h200; stride = 13'h10; cols = 8'd0; rows = 8'd2;
        start = 1'b1;
        tick; start = 1'b0;
        n_cmp++; if (done !== 1'b1 || addr_valid !== 1'b0 || busy !== 1'b0) begin
            n_bad++; $display("FAIL zero_done: got done=%b v=%b busy=%b want 1/0/0", done, addr_valid, busy);
        end
        tick;
        n_cmp++; if (done !== 1'b0 || addr_valid !== 1'b0) begin
            n_bad++; $display("FAIL zero_after: got done=%b v=%b want 0/0", done, addr_valid);
        end
    endtask

    task automatic test_start_in_run;
        load_basic; addr_ready = 1'b1; start = 1'b1;
        tick; start = 1'b0;
        for (int i = 0; i < 6; i++) begin
            if (i == 2) begin start = 1'b1; base_addr = 13'h500; cols = 8'd1; stride = 13'h3; end
            if (i == 3) start = 1'b0;
            n_cmp++; if (addr_valid !== 1'b1 || addr !== exp_a[i]) begin
                n_bad++; $display("FAIL run_start_addr[%0d]: got v=%b a=%h want v=1 a=%h", i, addr_valid, addr, exp_a[i]);
            end
            tick;
        end
        n_cmp++; if (done !== 1'b1) begin n_bad++; $display("FAIL run_start_done: got %b want 1", done); end
        tick;
    endtask

    task automatic test_start_stop_idle;
        load_basic; start = 1'b1; stop = 1'b1;
        tick;
        n_cmp++; if (busy !== 1'b0 || addr_valid !== 1'b0 || done !== 1'b0) begin
            n_bad++; $display("FAIL startstop: got busy=%b v=%b done=%b want 0/0/0", busy, addr_valid, done);
        end
        start = 1'b0; stop = 1'b0;
        tick;
        n_cmp++; if (busy !== 1'b0 || done !== 1'b0) begin
            n_bad++; $display("FAIL startstop_after: got busy=%b done=%b want 0/0", busy, done);
        end
    endtask

    task automatic test_abort;
        load_basic; addr_ready = 1'b1; start = 1'b1;
        tick; start = 1'b0;
        tick; tick;
        n_cmp++; if (addr !== 13'h102) begin n_bad++; $display("FAIL abort_pos: got %h want 102", addr); end
        stop = 1'b1;
        tick; stop = 1'b0;
        n_cmp++; if (addr_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
            n_bad++; $display("FAIL abort_stop: got v=%b busy=%b done=%b want 0/0/0", addr_valid, busy, done);
        end
        tick;
        n_cmp++; if (done !== 1'b0 || addr_valid !== 1'b0) begin
            n_bad++; $display("FAIL abort_after: got done=%b v=%b want 0/0", done, addr_valid);
        end
    endtask

    task automatic test_reset_mid_frame;
        load_basic; addr_ready = 1'b1; start = 1'b1;
        tick; start = 1'b0;
        tick;
        rst = 1'b1;
        #1;
        n_cmp++; if ({addr, addr_valid, line_start, busy, done} !== 17'h0) begin
            n_bad++; $display("FAIL rst_mid: got %h want 0", {addr, addr_valid, line_start, busy, done});
        end
        #1 rst = 1'b0;
        tick;
        n_cmp++; if (busy !== 1'b0 || addr_valid !== 1'b0) begin
            n_bad++; $display("FAIL rst_mid_after: got busy=%b v=%b want 0/0", busy, addr_valid);
        end
    endtask

`ifdef SCAN_FRAME_LOOP_EN
    task automatic test_frame_loop;
        base_addr = 13'h100; stride = 13'h0; cols = 8'd2; rows = 8'd1;
        addr_ready = 1'b1; start = 1'b1;
        tick; start = 1'b0;
        for (int i = 0; i < 8; i++) begin
            n_cmp++; if (addr !== ((i % 2 == 1) ? 13'h101 : 13'h100) || busy !== 1'b1) begin
                n_bad++; $display("FAIL loop_addr[%0d]: got a=%h busy=%b", i, addr, busy);
            end
            n_cmp++; if (done !== (i >= 2 && i % 2 == 0)) begin
                n_bad++; $display("FAIL loop_done[%0d]: got %b want %b", i, done, (i >= 2 && i % 2 == 0));
            end
            tick;
        end
        stop = 1'b1;
        tick; stop = 1'b0;
        n_cmp++; if (busy !== 1'b0 || done !== 1'b0) begin
            n_bad++; $display("FAIL loop_stop: got busy=%b done=%b want 0/0", busy, done);
        end
    endtask
`endif

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset;
        test_basic_frame;
        test_backpressure;
        test_wrap;
        test_zero_size;
        test_start_in_run;
        test_start_stop_idle;
        test_abort;
        test_reset_mid_frame;
`ifdef SCAN_FRAME_LOOP_EN
        test_frame_loop;
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
